axi_lite_cmd_master: RTL

- Upstream neighbour of the AXI4-Lite register slave.
- Converts a simple one-at-a-time command interface (register write/read requests from a controller or testbench sequencer) into AXI4-Lite master transactions on the five channels.
- Returns one response per command, with a cycle-count timeout that guards against a hung slave.

---
 rtl/axi_lite_cmd_master.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite command master: turns one-at-a-time register write/read commands
// into AXI4-Lite transactions and returns one response per command, with a hang timeout.
module axi_lite_cmd_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    axi_clk,
  input  logic                    axi_reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [2:0]              axi_awprot,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  input  logic [1:0]              axi_bresp,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [2:0]              axi_arprot,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]              axi_rresp,
  input  logic                    axi_rvalid,
  output logic                    axi_rready,
  output logic [2:0]              dbg_state
);

  // Handshake semantics: a transfer happens on a rising edge where valid and
  // ready are both 1; every valid/ready driven here is a flop, never a
  // combinational function of the partner's ready.

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_RAW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_WIDTH  = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
  localparam bit TMO_EN     = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST =
    CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RSP          = 3'd5
  } state_t;

  state_t                  state, state_nxt;
  logic                    cmd_ready_nxt, rsp_valid_nxt, rsp_timeout_nxt;
  logic [DATA_WIDTH-1:0]   rsp_rdata_nxt, wdata_nxt;
  logic [1:0]              rsp_resp_nxt;
  logic [ADDR_WIDTH-1:0]   awaddr_nxt, araddr_nxt;
  logic [STRB_WIDTH-1:0]   wstrb_nxt;
  logic                    awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
  logic [CNT_WIDTH-1:0]    tmo_cnt, cnt_nxt;
  logic                    tmo_hit, abort, aw_done, w_done;

  assign axi_awprot = 3'b000;
  assign axi_arprot = 3'b000;
  assign dbg_state  = state;

  // The edge that would bring the counter to TIMEOUT_CYCLES is the abort edge.
  assign tmo_hit = TMO_EN && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt       = state;
    cmd_ready_nxt   = cmd_ready;
    rsp_valid_nxt   = rsp_valid;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_resp_nxt    = rsp_resp;
    rsp_timeout_nxt = rsp_timeout;
    awaddr_nxt      = axi_awaddr;
    wdata_nxt       = axi_wdata;
    wstrb_nxt       = axi_wstrb;
    araddr_nxt      = axi_araddr;
    awvalid_nxt     = axi_awvalid;
    wvalid_nxt      = axi_wvalid;
    bready_nxt      = axi_bready;
    arvalid_nxt     = axi_arvalid;
    rready_nxt      = axi_rready;
    cnt_nxt         = tmo_cnt;
    abort           = 1'b0;
    aw_done         = !axi_awvalid || axi_awready;
    w_done          = !axi_wvalid || axi_wready;

    case (state)
      IDLE: begin
        cmd_ready_nxt = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_nxt   = 1'b0;
          cnt_nxt         = '0;
          rsp_timeout_nxt = 1'b0;
          if (cmd_write) begin
            awaddr_nxt  = cmd_addr;
            wdata_nxt   = cmd_wdata;
            wstrb_nxt   = cmd_wstrb;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            state_nxt   = WR_ADDR_DATA;
          end else begin
            araddr_nxt  = cmd_addr;
            arvalid_nxt = 1'b1;
            state_nxt   = RD_ADDR;
          end
        end
      end
      WR_ADDR_DATA: begin
        cnt_nxt = tmo_cnt + 1'b1;
        if (axi_awvalid && axi_awready) awvalid_nxt = 1'b0;
        if (axi_wvalid && axi_wready)   wvalid_nxt  = 1'b0;
        if (tmo_hit) begin
          abort = 1'b1;
        end else if (aw_done && w_done) begin
          bready_nxt = 1'b1;
          state_nxt  = WR_RESP;
        end
      end
      WR_RESP: begin
        cnt_nxt = tmo_cnt + 1'b1;
        if (axi_bvalid && axi_bready) begin
          rsp_resp_nxt  = axi_bresp;
          rsp_rdata_nxt = '0;
          bready_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RSP;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end
      RD_ADDR: begin
        cnt_nxt = tmo_cnt + 1'b1;
        if (tmo_hit) begin
          abort = 1'b1;
        end else if (axi_arvalid && axi_arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD_DATA;
        end
      end
      RD_DATA: begin
        cnt_nxt = tmo_cnt + 1'b1;
        if (axi_rvalid && axi_rready) begin
          rsp_rdata_nxt = axi_rdata;
          rsp_resp_nxt  = axi_rresp;
          rready_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RSP;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end
      RSP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abort abandons the slave: every AXI valid/ready is withdrawn at once.
    if (abort) begin
      awvalid_nxt     = 1'b0;
      wvalid_nxt      = 1'b0;
      bready_nxt      = 1'b0;
      arvalid_nxt     = 1'b0;
      rready_nxt      = 1'b0;
      rsp_timeout_nxt = 1'b1;
      rsp_resp_nxt    = 2'b10;
      rsp_rdata_nxt   = '0;
      rsp_valid_nxt   = 1'b1;
      state_nxt       = RSP;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
      axi_awaddr  <= '0;
      axi_wdata   <= '0;
      axi_wstrb   <= '0;
      axi_araddr  <= '0;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      cmd_ready   <= cmd_ready_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_resp    <= rsp_resp_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      axi_awaddr  <= awaddr_nxt;
      axi_wdata   <= wdata_nxt;
      axi_wstrb   <= wstrb_nxt;
      axi_araddr  <= araddr_nxt;
      axi_awvalid <= awvalid_nxt;
      axi_wvalid  <= wvalid_nxt;
      axi_bready  <= bready_nxt;
      axi_arvalid <= arvalid_nxt;
      axi_rready  <= rready_nxt;
      tmo_cnt     <= cnt_nxt;
    end
  end

endmodule
